seeg_miso_deskew: RTL and testbench

SEEG_MISO_DESKEW -- requirements
Module: seeg_miso_deskew

---
 rtl/seeg_miso_deskew.sv | 161 ++++++++++++++++
 tb/tb_seeg_miso_deskew.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seeg_miso_deskew.sv
// Per-line delay-compensated MISO capture for a multi-line SEEG SPI front end.
// Captures one word per line per frame and streams the words out over AXI-stream in line order.
module seeg_miso_deskew #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned DLY_BITS  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          frame_start,
  input  logic                          bit_strobe,
  input  logic [NUM_LINES-1:0]          miso,
  input  logic [NUM_LINES*DLY_BITS-1:0] miso_delay,
  output logic [WORD_BITS-1:0]          m_tdata,
  output logic [2:0]                    m_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned TAP_W  = 1 << DLY_BITS;
  localparam int unsigned HIST_W = TAP_W - 1;
  localparam int unsigned CNT_W  = $clog2(WORD_BITS + 1);
  localparam int unsigned IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic {IDLE, CAPTURE} cap_state_t;
  typedef enum logic {EMPTY, DRAIN}  buf_state_t;

  cap_state_t cap_state, cap_next;
  buf_state_t buf_state, buf_next;

  logic [HIST_W-1:0]    hist;
  logic [TAP_W-1:0]     taps;
  logic [DLY_BITS-1:0]  dly  [NUM_LINES];
  logic [WORD_BITS-1:0] sr   [NUM_LINES];
  logic [CNT_W-1:0]     cnt  [NUM_LINES];
  logic [WORD_BITS-1:0] bufw [NUM_LINES];
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     nxt_idx;

  logic [NUM_LINES-1:0] sample_c;
  logic all_done_c, frame_done_c, accept_c, last_accept_c, load_c, ovf_set_c;

  // Tap 0 is the live strobe, tap d is the strobe seen d cycles ago.
  assign taps = {hist, bit_strobe};
  assign nxt_idx = idx + IDX_W'(1);

  always_comb begin
    all_done_c = 1'b1;
    sample_c   = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (cnt[i] != CNT_W'(WORD_BITS)) all_done_c = 1'b0;
      sample_c[i] = (cap_state == CAPTURE) && taps[dly[i]] && (cnt[i] < CNT_W'(WORD_BITS));
    end
  end

  // A restart in the completion cycle wins: the finished frame is dropped.
  assign frame_done_c  = (cap_state == CAPTURE) && all_done_c && !frame_start;
  assign accept_c      = m_tvalid && m_tready;
  assign last_accept_c = accept_c && m_tlast;
  assign load_c        = frame_done_c && ((buf_state == EMPTY) || last_accept_c);
  assign ovf_set_c     = frame_done_c && !load_c;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cap_state <= IDLE;
    else        cap_state <= cap_next;
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      IDLE:    if (frame_start) cap_next = CAPTURE;
      CAPTURE: begin
        if (frame_start)     cap_next = CAPTURE;
        else if (all_done_c) cap_next = IDLE;
      end
      default: cap_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) buf_state <= EMPTY;
    else        buf_state <= buf_next;
  end

  always_comb begin
    buf_next = buf_state;
    case (buf_state)
      EMPTY:   if (load_c) buf_next = DRAIN;
      DRAIN:   if (last_accept_c && !load_c) buf_next = EMPTY;
      default: buf_next = EMPTY;
    endcase
  end

  // Capture datapath: strobe history, latched delays, per-line shifters and bit counts.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hist <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        dly[i] <= '0;
        sr[i]  <= '0;
        cnt[i] <= '0;
      end
    end else if (frame_start) begin
      hist <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        dly[i] <= miso_delay[i*DLY_BITS +: DLY_BITS];
        sr[i]  <= '0;
        cnt[i] <= '0;
      end
    end else if (cap_state == CAPTURE) begin
      if (all_done_c) hist <= '0;
      else            hist <= {hist[HIST_W-2:0], bit_strobe};
      for (int i = 0; i < NUM_LINES; i++) begin
        if (sample_c[i]) begin
          sr[i]  <= {sr[i][WORD_BITS-2:0], miso[i]};
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Output buffer and registered stream/status outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_LINES; i++) bufw[i] <= '0;
      idx      <= '0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load_c) begin
        for (int i = 0; i < NUM_LINES; i++) bufw[i] <= sr[i];
        idx     <= '0;
        m_tdata <= sr[0];
        m_tuser <= '0;
        m_tlast <= (NUM_LINES == 1);
      end else if (accept_c) begin
        if (!m_tlast) begin
          idx     <= nxt_idx;
          m_tdata <= bufw[nxt_idx];
          m_tuser <= 3'(nxt_idx);
          m_tlast <= (nxt_idx == IDX_W'(NUM_LINES - 1));
        end else begin
          m_tlast <= 1'b0;
        end
      end
      m_tvalid <= (buf_next == DRAIN);
      busy     <= (cap_next == CAPTURE);
      if (ovf_set_c)           overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seeg_miso_deskew.sv
// Directed self-checking bench for seeg_miso_deskew: delays, back-pressure, overflow, abort and reset.
module tb_seeg_miso_deskew;

  localparam int SP = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        frame_start, bit_strobe, m_tready, clear_overflow;
  logic [7:0]  miso;
  logic [31:0] miso_delay;
  logic [15:0] m_tdata;
  logic [2:0]  m_tuser;
  logic        m_tvalid, m_tlast, busy, overflow;

  int vectors = 0;
  int miscompares = 0;

  seeg_miso_deskew dut (
    .ACLK(ACLK), .ARESET(ARESET), .frame_start(frame_start), .bit_strobe(bit_strobe),
    .miso(miso), .miso_delay(miso_delay), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses frame_start, then drives 16 strobes SP apart; line i presents its bits lags[i] cycles late.
  // Returns in the cycle after the slowest line's last bit was sampled.
  task automatic run_frame(input logic [127:0] words, input logic [31:0] lags);
    int maxlag, l, k;
    logic [15:0] w;
    maxlag = 0;
    for (int i = 0; i < 8; i++) if (int'(lags[i*4 +: 4]) > maxlag) maxlag = int'(lags[i*4 +: 4]);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c <= 15*SP + maxlag; c++) begin
      bit_strobe = (c % SP == 0) && (c / SP < 16);
      for (int i = 0; i < 8; i++) begin
        l = int'(lags[i*4 +: 4]);
        w = words[i*16 +: 16];
        if (c < l) miso[i] = 1'b0;
        else begin
          k = (c - l) / SP;
          if (k > 15) k = 15;
          miso[i] = w[15 - k];
        end
      end
      if (c == 1) chk("busy_in_capture", 32'(busy), 32'd1);
      tick();
    end
    bit_strobe = 1'b0;
    miso = '0;
  endtask

  // Accepts n beats with ready held high and checks data, index and last flag of each.
  task automatic drain(input logic [127:0] exp, input int n, input bit check_end);
    int waited;
    m_tready = 1'b1;
    waited = 0;
    while (!m_tvalid && waited < 20) begin
      tick();
      waited++;
    end
    if (!m_tvalid) begin
      chk("tvalid_timeout", 32'(m_tvalid), 32'd1);
      m_tready = 1'b0;
      return;
    end
    for (int j = 0; j < n; j++) begin
      chk($sformatf("beat%0d_tvalid", j), 32'(m_tvalid), 32'd1);
      chk($sformatf("beat%0d_tdata", j), 32'(m_tdata), 32'(exp[j*16 +: 16]));
      chk($sformatf("beat%0d_tuser", j), 32'(m_tuser), 32'(j));
      chk($sformatf("beat%0d_tlast", j), 32'(m_tlast), 32'(j == 7));
      tick();
    end
    if (check_end) chk("tvalid_after_last", 32'(m_tvalid), 32'd0);
    m_tready = 1'b0;
  endtask

  function automatic logic [127:0] seq_words(input logic [15:0] base);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
    return r;
  endfunction

  function automatic logic [127:0] same_words(input logic [15:0] w);
    return {8{w}};
  endfunction

  initial begin
    ARESET = 1'b1;
    frame_start = 1'b0; bit_strobe = 1'b0; miso = '0; miso_delay = '0;
    m_tready = 1'b0; clear_overflow = 1'b0;
    tick(); tick(); tick();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_tvalid", 32'(m_tvalid), 32'd0);

    // Zero delay, distinct word per line.
    miso_delay = 32'h0000_0000;
    run_frame(seq_words(16'hA5A0), 32'h0000_0000);
    chk("z_tvalid_s1", 32'(m_tvalid), 32'd0);
    tick();
    chk("z_tvalid_s2", 32'(m_tvalid), 32'd1);
    chk("z_busy_idle", 32'(busy), 32'd0);
    drain(seq_words(16'hA5A0), 8, 1'b1);

    // Uniform 2-cycle lag compensated by delay 2.
    miso_delay = 32'h2222_2222;
    run_frame(same_words(16'h1234), 32'h2222_2222);
    drain(same_words(16'h1234), 8, 1'b1);
    // Same lag without compensation samples one bit early: first bit 0, then word>>1.
    miso_delay = 32'h0000_0000;
    run_frame(same_words(16'h1234), 32'h2222_2222);
    drain(same_words(16'h091A), 8, 1'b1);

    // Mixed per-line delays; latency measured from line 7's last bit.
    miso_delay = 32'h7654_3210;
    run_frame(same_words(16'hBEEF), 32'h7654_3210);
    chk("mix_tvalid_s1", 32'(m_tvalid), 32'd0);
    tick();
    chk("mix_tvalid_s2", 32'(m_tvalid), 32'd1);
    miso_delay = 32'hFFFF_FFFF;
    drain(same_words(16'hBEEF), 8, 1'b1);

    // Back-pressure through a second frame causes overflow; first frame survives intact.
    miso_delay = 32'h0000_0000;
    run_frame(seq_words(16'hC000), 32'h0000_0000);
    tick(); tick(); tick();
    chk("bp_hold_tvalid", 32'(m_tvalid), 32'd1);
    chk("bp_hold_tdata", 32'(m_tdata), 32'h0000_C000);
    chk("bp_hold_tuser", 32'(m_tuser), 32'd0);
    run_frame(seq_words(16'hD000), 32'h0000_0000);
    chk("bp_ovf_not_yet", 32'(overflow), 32'd0);
    tick();
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_tdata_kept", 32'(m_tdata), 32'h0000_C000);
    drain(seq_words(16'hC000), 8, 1'b1);
    tick(); tick();
    chk("bp_second_absent", 32'(m_tvalid), 32'd0);
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("bp_overflow_clear", 32'(overflow), 32'd0);

    // Abort after 7 strobes, then a complete frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 7*SP; c++) begin
      bit_strobe = (c % SP == 0);
      miso = 8'hFF;
      tick();
    end
    bit_strobe = 1'b0;
    miso = '0;
    chk("abort_busy", 32'(busy), 32'd1);
    run_frame(same_words(16'h0F0F), 32'h0000_0000);
    drain(same_words(16'h0F0F), 8, 1'b1);
    tick(); tick();
    chk("abort_single_frame", 32'(m_tvalid), 32'd0);
    chk("abort_no_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of draining.
    run_frame(seq_words(16'h5550), 32'h0000_0000);
    drain(seq_words(16'h5550), 3, 1'b0);
    m_tready = 1'b1;
    ARESET = 1'b1;
    #1;
    chk("mrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mrst_tdata", 32'(m_tdata), 32'd0);
    chk("mrst_tlast", 32'(m_tlast), 32'd0);
    tick(); tick();
    ARESET = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("mrst_no_beats", 32'(m_tvalid), 32'd0);
    m_tready = 1'b0;
    run_frame(seq_words(16'h6660), 32'h0000_0000);
    drain(seq_words(16'h6660), 8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
